// File: rtl/prbs_level_packer_if.sv
// Output stream of the level packer: one multi-level target word plus its address.
// Latency: n/a (signal bundle only).
// Backpressure: out_valid/out_ready; the master holds addr/level stable while out_valid is high and out_ready is low.
//
// Signals:
//   out_valid  master -> slave  word and address are valid
//   out_ready  slave  -> master consumer accepts when out_valid & out_ready
//   out_addr   master -> slave  address of the current word
//   out_level  master -> slave  packed cell levels, cell j at [4*j +: 4]
interface prbs_level_packer_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int LEVEL_WIDTH = 192
);
    logic                   out_valid;
    logic                   out_ready;
    logic [ADDR_WIDTH-1:0]  out_addr;
    logic [LEVEL_WIDTH-1:0] out_level;

    modport master (
        output out_valid,
        output out_addr,
        output out_level,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_level,
        output out_ready
    );
endinterface

// File: rtl/prbs_level_packer.sv
// Packs per-plane LFSR words into multi-level cell words and streams them with an address.
// Latency: start -> first out_valid in 2 cycles; one word per 3 cycles with out_ready held high.
// Backpressure: SEND holds out_valid, out_addr and out_level until out_ready; the LFSR is not stepped meanwhile.
//
// Ports:
//   clk, rst        clock and asynchronous active-low reset
//   start, abort    run control; abort wins over start and returns to IDLE
//   bits_per_cell   planes used per cell (clamped to 1..NUM_PLANES), captured at start
//   addr_start/stop inclusive address range, captured at start, wraps modulo 2^ADDR_WIDTH
//   lfsr_data       NUM_PLANES LFSR plane words, plane p at [p*WORD_SIZE +: WORD_SIZE]
//   lfsr_enable     one-cycle step request to the LFSR bank, only in ADV
//   out_if          master side of the word stream
//   busy, done      busy outside IDLE; done pulses once after the last word is accepted
module prbs_level_packer #(
    parameter int WORD_SIZE  = 48,
    parameter int NUM_PLANES = 4,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            abort,
    input  logic [2:0]                      bits_per_cell,
    input  logic [ADDR_WIDTH-1:0]           addr_start,
    input  logic [ADDR_WIDTH-1:0]           addr_stop,
    input  logic [NUM_PLANES*WORD_SIZE-1:0] lfsr_data,
    output logic                            lfsr_enable,
    output logic                            busy,
    output logic                            done,
    prbs_level_packer_if.master             out_if
);

    localparam int LEVEL_W = NUM_PLANES * WORD_SIZE;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_ADV   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                  state_q,       state_d;
    logic [NUM_PLANES-1:0]   plane_mask_q,  plane_mask_d;
    logic [ADDR_WIDTH-1:0]   addr_cnt_q,    addr_cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_stop_q,   addr_stop_d;
    logic [ADDR_WIDTH-1:0]   out_addr_q,    out_addr_d;
    logic [LEVEL_W-1:0]      out_level_q,   out_level_d;
    logic                    out_valid_q,   out_valid_d;
    logic                    lfsr_enable_q, lfsr_enable_d;
    logic                    busy_q,        busy_d;
    logic                    done_q,        done_d;

    logic [2:0]              bits_clamped;
    logic [NUM_PLANES-1:0]   plane_mask_new;
    logic [LEVEL_W-1:0]      level_map;
    logic                    handshake;

    // Clamp the requested cell depth into 1..NUM_PLANES and turn it into a
    // per-plane enable mask, so the datapath only needs an AND per bit.
    always_comb begin
        bits_clamped = bits_per_cell;
        if (bits_per_cell == 3'd0) begin
            bits_clamped = 3'd1;
        end else if (bits_per_cell > 3'(NUM_PLANES)) begin
            bits_clamped = 3'(NUM_PLANES);
        end
        plane_mask_new = '0;
        for (int p = 0; p < NUM_PLANES; p++) begin
            plane_mask_new[p] = (3'(p) < bits_clamped);
        end
    end

    // Transpose planes into cells: cell j takes bit j of every plane, with
    // plane p landing on bit p of the cell field. Disabled planes read as 0.
    always_comb begin
        level_map = '0;
        for (int j = 0; j < WORD_SIZE; j++) begin
            for (int p = 0; p < NUM_PLANES; p++) begin
                level_map[j*NUM_PLANES + p] = lfsr_data[p*WORD_SIZE + j] & plane_mask_q[p];
            end
        end
    end

    assign handshake = out_valid_q & out_if.out_ready;

    always_comb begin
        state_d       = state_q;
        plane_mask_d  = plane_mask_q;
        addr_cnt_d    = addr_cnt_q;
        addr_stop_d   = addr_stop_q;
        out_addr_d    = out_addr_q;
        out_level_d   = out_level_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    plane_mask_d = plane_mask_new;
                    addr_cnt_d   = addr_start;
                    addr_stop_d  = addr_stop;
                    state_d      = ST_FETCH;
                end
            end
            ST_FETCH: begin
                out_level_d = level_map;
                out_addr_d  = addr_cnt_q;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (handshake) begin
                    // Equality test (not magnitude) so a stop below start
                    // simply wraps through all-ones back to zero.
                    if (addr_cnt_q == addr_stop_q) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_cnt_d = addr_cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                        state_d    = ST_ADV;
                    end
                end
            end
            ST_ADV: begin
                // LFSR steps on the edge leaving ADV; FETCH sees the new data.
                state_d = ST_FETCH;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a coincident start in IDLE.
        if (abort) begin
            state_d = ST_IDLE;
        end

        // Outputs are registered copies of the next-state decode so they
        // change on the same edge as the state itself.
        out_valid_d   = (state_d == ST_SEND);
        lfsr_enable_d = (state_d == ST_ADV);
        done_d        = (state_d == ST_DONE);
        busy_d        = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            plane_mask_q  <= '0;
            addr_cnt_q    <= '0;
            addr_stop_q   <= '0;
            out_addr_q    <= '0;
            out_level_q   <= '0;
            out_valid_q   <= 1'b0;
            lfsr_enable_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            plane_mask_q  <= plane_mask_d;
            addr_cnt_q    <= addr_cnt_d;
            addr_stop_q   <= addr_stop_d;
            out_addr_q    <= out_addr_d;
            out_level_q   <= out_level_d;
            out_valid_q   <= out_valid_d;
            lfsr_enable_q <= lfsr_enable_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_addr  = out_addr_q;
    assign out_if.out_level = out_level_q;
    assign lfsr_enable      = lfsr_enable_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_prbs_level_packer.sv
module tb_prbs_level_packer;

    localparam int WS = 48;
    localparam int NP = 4;
    localparam int AW = 16;
    localparam int LW = NP * WS;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [2:0]    bits_per_cell = 3'd0;
    logic [AW-1:0] addr_start = '0;
    logic [AW-1:0] addr_stop = '0;
    logic [LW-1:0] lfsr_data;
    logic          lfsr_enable;
    logic          busy;
    logic          done;
    logic          ready = 1'b0;

    prbs_level_packer_if #(.ADDR_WIDTH(AW), .LEVEL_WIDTH(LW)) out_if ();
    assign out_if.out_ready = ready;

    prbs_level_packer #(.WORD_SIZE(WS), .NUM_PLANES(NP), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .bits_per_cell (bits_per_cell),
        .addr_start    (addr_start),
        .addr_stop     (addr_stop),
        .lfsr_data     (lfsr_data),
        .lfsr_enable   (lfsr_enable),
        .busy          (busy),
        .done          (done),
        .out_if        (out_if)
    );

    always #5 clk = ~clk;

    // ---------------- LFSR bank stand-in ----------------
    int   step = 0;
    logic force_ones = 1'b0;

    function automatic logic [WS-1:0] rotl(input logic [WS-1:0] x, input int s);
        if (s == 0) return x;
        return (x << s) | (x >> (WS - s));
    endfunction

    // Distinct, directed per-step plane contents.
    function automatic logic [LW-1:0] gen(input int k);
        logic [LW-1:0] d;
        d = '0;
        for (int p = 0; p < NP; p++) begin
            d[p*WS +: WS] = rotl(48'hA5C3_0F96_7E21, (k*5 + p*11) % WS) ^ {24'(k), 24'(p*3 + 1)};
        end
        return d;
    endfunction

    assign lfsr_data = force_ones ? {LW{1'b1}} : gen(step);

    always @(posedge clk) begin
        if (lfsr_enable) step <= step + 1;
    end

    // Reference level packing: cell j nibble = {plane3[j],plane2[j],plane1[j],plane0[j]},
    // planes at or above b zeroed.
    function automatic logic [LW-1:0] exp_level(input logic [LW-1:0] d, input int b);
        logic [LW-1:0] r;
        logic [3:0]    nib;
        r = '0;
        for (int j = 0; j < WS; j++) begin
            nib = 4'h0;
            for (int p = 0; p < NP; p++) begin
                if (p < b) nib[p] = d[p*WS + j];
            end
            r[4*j +: 4] = nib;
        end
        return r;
    endfunction

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [LW-1:0] level;
    } item_t;

    item_t exp_q[$];
    item_t mon_e;
    int    en_cnt   = 0;
    int    done_cnt = 0;

    task automatic push_model(input logic [AW-1:0] a0, input int n, input int b);
        item_t it;
        for (int i = 0; i < n; i++) begin
            it.addr  = AW'(a0 + i);
            it.level = exp_level(gen(step + i), b);
            exp_q.push_back(it);
        end
    endtask

    task automatic push_const(input logic [AW-1:0] a, input logic [LW-1:0] lvl);
        item_t it;
        it.addr  = a;
        it.level = lvl;
        exp_q.push_back(it);
    endtask

    // Monitor: pops one expected word per handshake, counts pulses.
    always @(negedge clk) begin
        if (lfsr_enable) begin
            en_cnt++;
            chk("enable_while_valid", LW'(out_if.out_valid), LW'(0));
        end
        if (done) done_cnt++;
        if (out_if.out_valid && out_if.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_word: got addr %h, required no word", out_if.out_addr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("word_addr", LW'(out_if.out_addr), LW'(mon_e.addr));
                chk("word_level", out_if.out_level, mon_e.level);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int en0 = 0;
    int d0  = 0;

    task automatic launch(input logic [2:0] bits, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        @(posedge clk); #1;
        en0 = en_cnt;
        d0  = done_cnt;
        bits_per_cell = bits;
        addr_start    = a0;
        addr_stop     = a1;
        start         = 1'b1;
        @(posedge clk); #1;
        start         = 1'b0;
        // Scramble inputs to show the configuration was captured.
        bits_per_cell = 3'd0;
        addr_start    = 16'h5555;
        addr_stop     = 16'hAAAA;
    endtask

    task automatic finish_run(input string name, input int exp_en);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 500);
        chk({name, "_done_seen"}, LW'(done), LW'(1));
        @(negedge clk);
        chk({name, "_enables"}, LW'(en_cnt - en0), LW'(exp_en));
        chk({name, "_done_pulses"}, LW'(done_cnt - d0), LW'(1));
        chk({name, "_idle_after"}, LW'(busy), LW'(0));
    endtask

    task automatic wait_valid(input string name);
        int c;
        c = 0;
        while (!out_if.out_valid && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk(name, LW'(out_if.out_valid), LW'(1));
    endtask

    logic [AW-1:0] hold_addr;
    logic [LW-1:0] hold_lvl;
    int            bp_bad;

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", LW'(out_if.out_valid), LW'(0));
        chk("rst_busy", LW'(busy), LW'(0));
        chk("rst_done", LW'(done), LW'(0));
        chk("rst_enable", LW'(lfsr_enable), LW'(0));
        chk("rst_addr", LW'(out_if.out_addr), LW'(0));
        chk("rst_level", out_if.out_level, LW'(0));
        rst = 1'b1;

        // 1: b=1, three words 0..2, ready held high
        ready = 1'b1;
        push_model(16'h0000, 3, 1);
        launch(3'd1, 16'h0000, 16'h0002);
        finish_run("t1", 2);

        // 2: all-ones planes, b=4 then b=2
        force_ones = 1'b1;
        push_const(16'h0010, {WS{4'hF}});
        launch(3'd4, 16'h0010, 16'h0010);
        finish_run("t2a", 0);
        push_const(16'h0011, {WS{4'h3}});
        launch(3'd2, 16'h0011, 16'h0011);
        finish_run("t2b", 0);
        force_ones = 1'b0;

        // 3: backpressure for 5 cycles on the first word
        ready = 1'b0;
        push_model(16'h0005, 2, 3);
        launch(3'd3, 16'h0005, 16'h0006);
        wait_valid("t3_valid");
        hold_addr = out_if.out_addr;
        hold_lvl  = out_if.out_level;
        chk("t3_first_addr", LW'(hold_addr), LW'(16'h0005));
        bp_bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_if.out_valid !== 1'b1 || lfsr_enable !== 1'b0 ||
                out_if.out_addr !== hold_addr || out_if.out_level !== hold_lvl) bp_bad++;
        end
        chk("t3_stall_stable", LW'(bp_bad), LW'(0));
        ready = 1'b1;
        finish_run("t3", 1);

        // 4: address wrap FFFE..0001
        push_model(16'hFFFE, 4, 4);
        launch(3'd4, 16'hFFFE, 16'h0001);
        finish_run("t4", 3);

        // 5: clamping of bits_per_cell
        push_model(16'h0020, 2, 1);
        launch(3'd0, 16'h0020, 16'h0021);
        finish_run("t5a", 1);
        push_model(16'h0030, 1, 4);
        launch(3'd7, 16'h0030, 16'h0030);
        finish_run("t5b", 0);

        // 6a: abort while the second word waits in SEND
        ready = 1'b0;
        push_model(16'h0040, 1, 2);
        launch(3'd2, 16'h0040, 16'h0045);
        wait_valid("t6_valid_w0");
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        wait_valid("t6_valid_w1");
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("t6_abort_valid", LW'(out_if.out_valid), LW'(0));
        chk("t6_abort_busy", LW'(busy), LW'(0));
        chk("t6_abort_enable", LW'(lfsr_enable), LW'(0));
        repeat (3) @(negedge clk);
        chk("t6_abort_no_done", LW'(done_cnt - d0), LW'(0));
        chk("t6_abort_enables", LW'(en_cnt - en0), LW'(1));

        // 6b: abort and start together in IDLE -> start dropped
        abort = 1'b1;
        start = 1'b1;
        bits_per_cell = 3'd1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        chk("t6_abort_beats_start", LW'(busy), LW'(0));
        @(posedge clk); #1;
        chk("t6_still_idle", LW'(busy), LW'(0));

        // 6c: asynchronous reset mid-run
        launch(3'd1, 16'h0060, 16'h0062);
        wait_valid("t6_valid_rst");
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_valid", LW'(out_if.out_valid), LW'(0));
        chk("t6_rst_busy", LW'(busy), LW'(0));
        @(posedge clk); #1;
        rst = 1'b1;

        // 6d: rerun continues from the LFSR step reached so far
        ready = 1'b1;
        push_model(16'h0070, 2, 1);
        launch(3'd1, 16'h0070, 16'h0071);
        finish_run("t6_rerun", 1);

        repeat (2) @(posedge clk);
        chk("queue_empty", LW'(exp_q.size()), LW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case something wedges beyond all per-wait bounds.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
